// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer
//   Stage controller for a sequential in-place radix-2 FFT. A frame runs SIZE
//   butterfly stages. Each stage pulses the address generator start, waits
//   for stage_done, then waits PIPE_LAT cycles for the write pipeline to drain.
//   The ping-pong bank select toggles every stage. A watchdog moves to ERR if a
//   stage never reports completion within TIMEOUT cycles.
//
// Ports
//   clk, rst      clock and synchronous active-high reset
//   frame_start   start a frame (IDLE only)
//   stage_done    address generator finished the stage (RUN only)
//   err_clr       leave ERR (ERR only)
//   frame_ready   high in IDLE
//   busy          high in START/RUN/DRAIN/NEXT/DONE
//   stage_start   one-cycle pulse per stage
//   stage_idx     current stage number
//   bank_sel      read bank of current stage (write bank is the other one)
//   frame_done    one-cycle pulse after the last stage drained
//   result_bank   bank holding the final result, valid from frame_done
//   err           high while in ERR
//
// state | meaning
// IDLE  | waiting for frame_start
// START | stage_start pulse, watchdog cleared
// RUN   | waiting for stage_done, watchdog counting
// DRAIN | write pipeline draining
// NEXT  | advance stage index and swap banks
// DONE  | frame_done pulse
// ERR   | watchdog expired, waiting for err_clr
module fft_stage_sequencer #(
  parameter int N        = 16,
  parameter int SIZE     = 4,
  parameter int STG_W    = 3,
  parameter int PIPE_LAT = 4,
  parameter int TIMEOUT  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             stage_done,
  input  logic             err_clr,
  output logic             frame_ready,
  output logic             busy,
  output logic             stage_start,
  output logic [STG_W-1:0] stage_idx,
  output logic             bank_sel,
  output logic             frame_done,
  output logic             result_bank,
  output logic             err
);

  localparam int TMR_W = $clog2(TIMEOUT);
  localparam int DRN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(SIZE - 1);
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TIMEOUT - 1);
  localparam logic [DRN_W-1:0] DRN_INIT   = DRN_W'(PIPE_LAT - 1);

  // Parameter consistency is caught at elaboration rather than silently
  // producing a wrong stage count.
  if (N != (1 << SIZE)) begin : g_bad_n
    $error("fft_stage_sequencer: N must equal 2**SIZE");
  end
  if ((1 << STG_W) <= (SIZE - 1)) begin : g_bad_stg_w
    $error("fft_stage_sequencer: STG_W too narrow for SIZE");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_RUN, S_DRAIN, S_NEXT, S_DONE, S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [DRN_W-1:0] drain_q, drain_d;
  logic [STG_W-1:0] idx_d;
  logic             bank_d;
  logic             rbank_d;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    drain_d = drain_q;
    idx_d   = stage_idx;
    bank_d  = bank_sel;
    rbank_d = result_bank;
    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d = S_START;
          idx_d   = '0;
          bank_d  = 1'b0;
        end
      end
      S_START: begin
        timer_d = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        // completion on the terminal watchdog cycle still counts as done
        if (stage_done) begin
          state_d = S_DRAIN;
          drain_d = DRN_INIT;
        end else if (timer_q == TMR_LAST) begin
          state_d = S_ERR;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) begin
          if (stage_idx == LAST_STAGE) begin
            state_d = S_DONE;
            // captured on entry to DONE so it is valid alongside frame_done
            rbank_d = ~bank_sel;
          end else begin
            state_d = S_NEXT;
          end
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      S_NEXT: begin
        idx_d   = stage_idx + 1'b1;
        bank_d  = ~bank_sel;
        state_d = S_START;
      end
      S_DONE: state_d = S_IDLE;
      S_ERR: begin
        if (err_clr) begin
          state_d = S_IDLE;
          idx_d   = '0;
          bank_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet
  // aligned with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      drain_q     <= '0;
      stage_idx   <= '0;
      bank_sel    <= 1'b0;
      result_bank <= 1'b0;
      frame_ready <= 1'b1;
      busy        <= 1'b0;
      stage_start <= 1'b0;
      frame_done  <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      drain_q     <= drain_d;
      stage_idx   <= idx_d;
      bank_sel    <= bank_d;
      result_bank <= rbank_d;
      frame_ready <= (state_d == S_IDLE);
      busy        <= (state_d != S_IDLE) && (state_d != S_ERR);
      stage_start <= (state_d == S_START);
      frame_done  <= (state_d == S_DONE);
      err         <= (state_d == S_ERR);
    end
  end

endmodule
